// File: rtl/hvac_plant_scheduler.sv
// Shares one heating/cooling plant between N_ZONES zones.
// Picks one plant mode at a time, drives the dampers of the zones being served,
// and enforces minimum-on, minimum-off and maximum-run anti-short-cycle timing.
module hvac_plant_scheduler #(
    parameter int unsigned N_ZONES = 4,
    parameter int unsigned MIN_ON  = 8,
    parameter int unsigned MIN_OFF = 4,
    parameter int unsigned MAX_RUN = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_ZONES-1:0] heat_req,
    input  logic [N_ZONES-1:0] cool_req,
    output logic               heating,
    output logic               cooling,
    output logic [N_ZONES-1:0] damper,
    output logic [1:0]         state
);

    localparam int unsigned RW = $clog2(MAX_RUN + 1);
    localparam int unsigned OW = $clog2(MIN_OFF + 1);

    localparam logic [RW-1:0] C_MIN_ON_M1  = RW'(MIN_ON - 1);
    localparam logic [RW-1:0] C_MAX_RUN_M1 = RW'(MAX_RUN - 1);
    localparam logic [RW-1:0] C_MAX_RUN    = RW'(MAX_RUN);
    localparam logic [OW-1:0] C_MIN_OFF_M1 = OW'(MIN_OFF - 1);
    localparam logic [OW-1:0] C_MIN_OFF    = OW'(MIN_OFF);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_COOL = 2'b01,
        S_HEAT = 2'b10,
        S_LOCK = 2'b11
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [RW-1:0]      r_run_cnt;
    logic [OW-1:0]      r_off_cnt;
    logic               r_last_heat;
    logic               r_heating;
    logic               r_cooling;
    logic [N_ZONES-1:0] r_damper;
    logic [N_ZONES-1:0] w_damper_nxt;

    // A zone asking for both modes at once is treated as asking for neither
    logic [N_ZONES-1:0] w_hv;
    logic [N_ZONES-1:0] w_cv;
    logic               w_any_h;
    logic               w_any_c;
    logic               w_min_done;
    logic               w_max_done;

    assign w_hv       = heat_req & ~cool_req;
    assign w_cv       = cool_req & ~heat_req;
    assign w_any_h    = |w_hv;
    assign w_any_c    = |w_cv;
    assign w_min_done = (r_run_cnt >= C_MIN_ON_M1);
    assign w_max_done = (r_run_cnt >= C_MAX_RUN_M1);

    // Next-state selection and next damper pattern
    always_comb begin
        w_state_nxt  = r_state;
        w_damper_nxt = '0;
        case (r_state)
            S_IDLE: begin
                if (w_any_h && w_any_c) begin
                    w_state_nxt = r_last_heat ? S_COOL : S_HEAT;
                end else if (w_any_h) begin
                    w_state_nxt = S_HEAT;
                end else if (w_any_c) begin
                    w_state_nxt = S_COOL;
                end
            end
            S_HEAT: begin
                if (w_min_done && (!w_any_h || (w_max_done && w_any_c))) begin
                    w_state_nxt = S_LOCK;
                end
            end
            S_COOL: begin
                if (w_min_done && (!w_any_c || (w_max_done && w_any_h))) begin
                    w_state_nxt = S_LOCK;
                end
            end
            default: begin
                if (r_off_cnt >= C_MIN_OFF_M1) begin
                    w_state_nxt = S_IDLE;
                end
            end
        endcase
        if (w_state_nxt == S_HEAT) begin
            w_damper_nxt = w_hv;
        end else if (w_state_nxt == S_COOL) begin
            w_damper_nxt = w_cv;
        end
    end

    // State register, registered plant/damper drives and run/off timers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_heating   <= 1'b0;
            r_cooling   <= 1'b0;
            r_damper    <= '0;
            r_run_cnt   <= '0;
            r_off_cnt   <= '0;
            r_last_heat <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_heating <= (w_state_nxt == S_HEAT);
            r_cooling <= (w_state_nxt == S_COOL);
            r_damper  <= w_damper_nxt;

            if ((r_state == S_IDLE) && ((w_state_nxt == S_HEAT) || (w_state_nxt == S_COOL))) begin
                r_run_cnt   <= '0;
                r_last_heat <= (w_state_nxt == S_HEAT);
            end else if (((r_state == S_HEAT) || (r_state == S_COOL)) && (r_run_cnt != C_MAX_RUN)) begin
                r_run_cnt <= r_run_cnt + RW'(1);
            end

            if (r_state != S_LOCK) begin
                r_off_cnt <= '0;
            end else if (r_off_cnt != C_MIN_OFF) begin
                r_off_cnt <= r_off_cnt + OW'(1);
            end
        end
    end

    assign heating = r_heating;
    assign cooling = r_cooling;
    assign damper  = r_damper;
    assign state   = r_state;

endmodule
